// File: rtl/slave_req_arbiter.sv
// Round-robin arbiter between a multi-beat write request path and a single-beat
// read request path feeding one downstream beat interface.
module slave_req_arbiter #(
    parameter int BEAT_W = 4
) (
    input  logic              axi_clk,
    input  logic              ARESTn,
    input  logic              axi_wrreq_hdr_valid,
    input  logic [BEAT_W-1:0] axi_wrreq_beats,
    input  logic              axi_rdreq_hdr_valid,
    input  logic              tx_ready,
    output logic              axi_req_wr_grant,
    output logic              axi_req_rd_grant,
    output logic              axi_req_wr_sop,
    output logic              req_sel,
    output logic              arb_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_XFER = 2'd1,
        RD_XFER = 2'd2
    } state_t;

    localparam logic [BEAT_W-1:0] CNT_ZERO = {BEAT_W{1'b0}};
    localparam logic [BEAT_W-1:0] CNT_ONE  = BEAT_W'(1'b1);

    state_t            state_r;
    state_t            state_s;
    logic [BEAT_W-1:0] beat_cnt_r;
    logic [BEAT_W-1:0] beat_cnt_s;
    logic              rr_last_r;
    logic              rr_last_s;
    logic              req_sel_r;
    logic              req_sel_s;
    logic              first_r;
    logic              first_s;
    logic              wr_grant_s;
    logic              rd_grant_s;
    logic              sop_s;

    // State, beat counter, round-robin history and first-beat flag registers.
    always_ff @(posedge axi_clk or negedge ARESTn) begin
        if (!ARESTn) begin
            state_r    <= IDLE;
            beat_cnt_r <= CNT_ZERO;
            rr_last_r  <= 1'b1;
            req_sel_r  <= 1'b0;
            first_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            beat_cnt_r <= beat_cnt_s;
            rr_last_r  <= rr_last_s;
            req_sel_r  <= req_sel_s;
            first_r    <= first_s;
        end
    end

    // Next-state selection and grant generation.
    always_comb begin
        state_s    = state_r;
        beat_cnt_s = beat_cnt_r;
        rr_last_s  = rr_last_r;
        req_sel_s  = req_sel_r;
        first_s    = first_r;
        wr_grant_s = 1'b0;
        rd_grant_s = 1'b0;
        sop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                // rr_last high means the read path went last, so write wins a tie.
                if (axi_wrreq_hdr_valid && (!axi_rdreq_hdr_valid || rr_last_r)) begin
                    state_s    = WR_XFER;
                    beat_cnt_s = axi_wrreq_beats;
                    rr_last_s  = 1'b0;
                    req_sel_s  = 1'b0;
                    first_s    = 1'b1;
                end else if (axi_rdreq_hdr_valid) begin
                    state_s    = RD_XFER;
                    rr_last_s  = 1'b1;
                    req_sel_s  = 1'b1;
                    first_s    = 1'b0;
                end else begin
                    state_s    = IDLE;
                end
            end
            WR_XFER: begin
                wr_grant_s = tx_ready;
                sop_s      = tx_ready & first_r;
                if (tx_ready) begin
                    first_s = 1'b0;
                    // Holding at zero on the final beat keeps the counter from wrapping.
                    if (beat_cnt_r == CNT_ZERO) begin
                        state_s = IDLE;
                    end else begin
                        beat_cnt_s = beat_cnt_r - CNT_ONE;
                    end
                end else begin
                    state_s = WR_XFER;
                end
            end
            RD_XFER: begin
                rd_grant_s = tx_ready;
                if (tx_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RD_XFER;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign axi_req_wr_grant = wr_grant_s;
    assign axi_req_rd_grant = rd_grant_s;
    assign axi_req_wr_sop   = sop_s;
    assign req_sel          = req_sel_r;
    assign arb_busy         = (state_r != IDLE);

endmodule

// File: tb/tb_slave_req_arbiter.sv
// Scoreboard bench for slave_req_arbiter: a transaction-level model queues the
// expected beats at commit time and a negedge monitor pops them on every grant.
module tb_slave_req_arbiter;

    localparam int BEAT_W = 4;

    logic              axi_clk = 1'b0;
    logic              ARESTn;
    logic              axi_wrreq_hdr_valid;
    logic [BEAT_W-1:0] axi_wrreq_beats;
    logic              axi_rdreq_hdr_valid;
    logic              tx_ready;
    logic              axi_req_wr_grant;
    logic              axi_req_rd_grant;
    logic              axi_req_wr_sop;
    logic              req_sel;
    logic              arb_busy;

    slave_req_arbiter #(.BEAT_W(BEAT_W)) dut (
        .axi_clk             (axi_clk),
        .ARESTn              (ARESTn),
        .axi_wrreq_hdr_valid (axi_wrreq_hdr_valid),
        .axi_wrreq_beats     (axi_wrreq_beats),
        .axi_rdreq_hdr_valid (axi_rdreq_hdr_valid),
        .tx_ready            (tx_ready),
        .axi_req_wr_grant    (axi_req_wr_grant),
        .axi_req_rd_grant    (axi_req_rd_grant),
        .axi_req_wr_sop      (axi_req_wr_sop),
        .req_sel             (req_sel),
        .arb_busy            (arb_busy)
    );

    always #5 axi_clk = ~axi_clk;

    typedef struct {
        bit rd;
        bit sop;
    } beat_t;

    beat_t exp_q[$];
    beat_t popped;
    int    checks = 0;
    int    errors = 0;
    int    wr_count = 0;

    // Transaction-level reference: grants still owed, which path owns them, and who went last.
    int    remaining;
    bit    cur_rd;
    bit    sel_m;
    bit    last_rd;
    bit    pick_rd_m;
    int    n_m;
    bit    busy_e;

    assign pick_rd_m = axi_rdreq_hdr_valid && (!axi_wrreq_hdr_valid || !last_rd);
    assign n_m       = pick_rd_m ? 1 : int'(axi_wrreq_beats) + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: commit a transaction from IDLE, then consume one beat per ready cycle.
    always @(posedge axi_clk or negedge ARESTn) begin
        if (!ARESTn) begin
            remaining <= 0;
            cur_rd    <= 1'b0;
            sel_m     <= 1'b0;
            last_rd   <= 1'b1;
            exp_q.delete();
        end else if (remaining > 0) begin
            if (tx_ready) remaining <= remaining - 1;
        end else if (axi_wrreq_hdr_valid || axi_rdreq_hdr_valid) begin
            remaining <= n_m;
            cur_rd    <= pick_rd_m;
            sel_m     <= pick_rd_m;
            last_rd   <= pick_rd_m;
            for (int i = 0; i < n_m; i++)
                exp_q.push_back('{rd: pick_rd_m, sop: (!pick_rd_m && i == 0)});
        end
    end

    // Monitor: compare outputs mid-cycle and pop the scoreboard on each grant.
    always @(negedge axi_clk) begin
        if (!ARESTn) begin
            chk("outputs_in_reset",
                {27'd0, axi_req_wr_grant, axi_req_rd_grant, axi_req_wr_sop, req_sel, arb_busy}, 32'd0);
        end else begin
            busy_e = (remaining > 0);
            chk("arb_busy", arb_busy, busy_e);
            chk("wr_grant", axi_req_wr_grant, busy_e && !cur_rd && tx_ready);
            chk("rd_grant", axi_req_rd_grant, busy_e && cur_rd && tx_ready);
            chk("req_sel", req_sel, sel_m);
            if (axi_req_wr_grant || axi_req_rd_grant) begin
                if (axi_req_wr_grant) wr_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_available actual=grant expected=no_grant at %0t", $time);
                end else begin
                    popped = exp_q.pop_front();
                    chk("beat_kind", axi_req_rd_grant, popped.rd);
                    chk("beat_sop", axi_req_wr_sop, popped.sop);
                end
            end else begin
                chk("sop_no_grant", axi_req_wr_sop, 1'b0);
            end
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge axi_clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        axi_wrreq_hdr_valid = 1'b0;
        axi_rdreq_hdr_valid = 1'b0;
        axi_wrreq_beats     = 4'd0;
        tx_ready            = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        ARESTn = 1'b0;
        step(3);
        ARESTn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

    int c0;

    initial begin
        idle_inputs();
        ARESTn = 1'b0;
        #2;
        chk("reset_busy", arb_busy, 1'b0);
        step(2);
        ARESTn = 1'b1;
        step(2);

        // Four-beat write with continuous ready.
        axi_wrreq_hdr_valid = 1'b1;
        axi_wrreq_beats     = 4'd3;
        c0 = wr_count;
        step();
        axi_wrreq_hdr_valid = 1'b0;
        axi_wrreq_beats     = 4'd9;
        step(6);
        chk("wr4_grant_count", wr_count - c0, 32'd4);

        // Contended valids from reset alternate W, R, W, R.
        do_reset();
        axi_wrreq_hdr_valid = 1'b1;
        axi_rdreq_hdr_valid = 1'b1;
        axi_wrreq_beats     = 4'd0;
        step(8);
        idle_inputs();
        step(2);

        // Three-beat write stalled by a ready pattern 1,0,0,1,1.
        axi_wrreq_hdr_valid = 1'b1;
        axi_wrreq_beats     = 4'd2;
        step();
        axi_wrreq_hdr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tx_ready = (i == 1 || i == 2) ? 1'b0 : 1'b1;
            step();
        end
        chk("stall_back_to_idle", arb_busy, 1'b0);
        step(2);

        // Read stalled ten cycles with its valid dropped.
        tx_ready            = 1'b0;
        axi_rdreq_hdr_valid = 1'b1;
        step();
        axi_rdreq_hdr_valid = 1'b0;
        step(10);
        chk("rd_held", arb_busy, 1'b1);
        tx_ready = 1'b1;
        step(3);

        // Reset lands on the second beat of an eight-beat write; a pending read follows.
        do_reset();
        axi_wrreq_hdr_valid = 1'b1;
        axi_wrreq_beats     = 4'd7;
        step(2);
        chk("second_beat_grant", axi_req_wr_grant, 1'b1);
        #2;
        ARESTn = 1'b0;
        #1;
        chk("grant_drop_at_reset",
            {28'd0, axi_req_wr_grant, axi_req_rd_grant, axi_req_wr_sop, arb_busy}, 32'd0);
        axi_wrreq_hdr_valid = 1'b0;
        axi_rdreq_hdr_valid = 1'b1;
        step(2);
        ARESTn = 1'b1;
        step();
        chk("rd_after_reset", axi_req_rd_grant, 1'b1);
        axi_rdreq_hdr_valid = 1'b0;
        step(2);

        // Maximum length write: sixteen beats, no wrap.
        axi_wrreq_hdr_valid = 1'b1;
        axi_wrreq_beats     = 4'd15;
        c0 = wr_count;
        step();
        axi_wrreq_hdr_valid = 1'b0;
        step(20);
        chk("max_len_grant_count", wr_count - c0, 32'd16);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            axi_wrreq_hdr_valid = ($urandom_range(0, 2) != 0);
            axi_rdreq_hdr_valid = ($urandom_range(0, 2) != 0);
            axi_wrreq_beats     = 4'($urandom_range(0, 15));
            tx_ready            = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 399) == 0) begin
                #2;
                ARESTn = 1'b0;
                step(2);
                ARESTn = 1'b1;
            end
            step();
        end

        idle_inputs();
        step(40);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        chk("model_idle_at_end", arb_busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slave_req_arbiter.md
SLAVE_REQ_ARBITER -- requirements
Module: slave_req_arbiter

Interface
REQ-001 The block SHALL have parameter BEAT_W, default 4: width of the write beat-count field; a write transaction spans 1..2^BEAT_W grant cycles.
REQ-002 The block SHALL have port axi_clk  input  1: sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port ARESTn  input  1: asynchronous, active-low reset.
REQ-004 The block SHALL have port axi_wrreq_hdr_valid  input  1: write-request header ready at the write pop path.
REQ-005 The block SHALL have port axi_wrreq_beats  input  BEAT_W: write transaction length minus 1, in grant cycles; the header cycle counts as one of these cycles.
REQ-006 The block SHALL have port axi_rdreq_hdr_valid  input  1: read-request header ready at the read pop path.
REQ-007 The block SHALL have port tx_ready  input  1: downstream accepts one beat this cycle.
REQ-008 The block SHALL have port axi_req_wr_grant  output  1: write beat transferred/popped this cycle.
REQ-009 The block SHALL have port axi_req_rd_grant  output  1: read header transferred/popped this cycle.
REQ-010 The block SHALL have port axi_req_wr_sop  output  1: current write grant is the header (first) beat.
REQ-011 The block SHALL have port req_sel  output  1: datapath mux select, 0 = write path, 1 = read path.
REQ-012 The block SHALL have port arb_busy  output  1: a transaction is committed and not yet complete.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WR_XFER, RD_XFER; the state is registered.
REQ-014 In IDLE with only axi_wrreq_hdr_valid high, the FSM SHALL go to WR_XFER next cycle, load beat_cnt <= axi_wrreq_beats, and set req_sel <= 0.
REQ-015 In IDLE with only axi_rdreq_hdr_valid high, the FSM SHALL go to RD_XFER next cycle and set req_sel <= 1.
REQ-016 In IDLE with both valids high, the FSM SHALL pick the path opposite to the rr_last register: rr_last = 0 (last was write) picks read; rr_last = 1 picks write.
REQ-017 rr_last SHALL update to the chosen path on every IDLE exit; it SHALL NOT change otherwise.
REQ-018 In WR_XFER, axi_req_wr_grant SHALL equal tx_ready combinationally; axi_req_rd_grant SHALL be 0.
REQ-019 In WR_XFER, beat_cnt SHALL decrement on each granted cycle.
REQ-020 In WR_XFER, a granted cycle with beat_cnt == 0 SHALL return the FSM to IDLE next cycle.
REQ-021 axi_req_wr_sop SHALL be high only on the first granted cycle of a WR_XFER, tracked by a registered first-beat flag set on entry and cleared on the first grant.
REQ-022 In RD_XFER, axi_req_rd_grant SHALL equal tx_ready; the first granted cycle SHALL return the FSM to IDLE.
REQ-023 In IDLE, both grants and axi_req_wr_sop SHALL be 0 regardless of tx_ready.
REQ-024 Grant latency SHALL be 1 cycle minimum from valid high in IDLE to the first possible grant.
REQ-025 Between consecutive transactions there SHALL be exactly one IDLE cycle.
REQ-026 tx_ready low SHALL stall the current transaction indefinitely with no state or counter change.
REQ-027 Once a transaction is committed, deassertion of its valid SHALL be ignored; the transaction completes.
REQ-028 axi_wrreq_beats SHALL be sampled only on the IDLE->WR_XFER transition; later changes SHALL have no effect.
REQ-029 axi_wrreq_beats = 2^BEAT_W-1 SHALL produce exactly 2^BEAT_W write grants, with no counter wrap before completion.
REQ-030 arb_busy SHALL be high whenever state != IDLE.
REQ-031 axi_req_wr_grant and axi_req_rd_grant SHALL never be high in the same cycle.

Reset
REQ-032 On ARESTn low, the block SHALL asynchronously force state = IDLE, beat_cnt = 0, rr_last = 1 (so the first contended pick is write), req_sel = 0, and the first-beat flag = 0.
REQ-033 During reset, all outputs SHALL be 0, including mid-transfer, and grants SHALL drop in the same cycle reset asserts.
REQ-034 After reset release, the first arbitration SHALL occur on the first rising edge with ARESTn high.

Verification
REQ-035 Write only, beats=3, tx_ready=1 -> 4 consecutive wr_grant cycles starting 1 cycle after valid; sop on the first only; arb_busy high 4 cycles.
REQ-036 Both valids held high, write beats=0, tx_ready=1, from reset -> grant order W, R, W, R with one IDLE cycle between each; req_sel toggles 0,1,0,1.
REQ-037 Write beats=2 with tx_ready pattern 1,0,0,1,1 -> wr_grant 1,0,0,1,1; sop only on the first; return to IDLE after the 5th cycle.
REQ-038 Read in progress with tx_ready=0 for 10 cycles, rd valid dropped -> rd_grant stays 0, FSM holds RD_XFER, then exactly 1 rd_grant when tx_ready=1.
REQ-039 ARESTn asserted during the 2nd beat of a beats=7 write -> grants 0 in the same cycle; after release, a pending read wins with a 1-cycle latency.
REQ-040 BEAT_W=4, beats=15 -> exactly 16 wr_grants, with no extra or missing beats.
